// File: rtl/ext_tran_pkg.sv
// Shared encodings for the host-initiated Wishbone transaction master.
package ext_tran_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned SEL_W           = 4;
  localparam int unsigned DEFAULT_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Counter must be able to hold the timeout value itself.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/ext_tran_lanes.sv
// Little-endian byte-lane steering: selects, write replication, read alignment
// and the legality check for a request.
module ext_tran_lanes
  import ext_tran_pkg::*;
(
  input  logic [1:0]        req_addr_lo,
  input  size_e             req_size,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        rsp_addr_lo,
  input  size_e             rsp_size,
  input  logic [DATA_W-1:0] rsp_data,
  output logic [SEL_W-1:0]  sel_c,
  output logic [DATA_W-1:0] wdat_c,
  output logic [DATA_W-1:0] rdat_c,
  output logic              legal_c
);

  logic [DATA_W-1:0] rsp_shift;

  always_comb begin
    sel_c   = '0;
    wdat_c  = req_data;
    legal_c = 1'b0;
    case (req_size)
      SIZE_BYTE: begin
        sel_c   = 4'b0001 << req_addr_lo;
        wdat_c  = {4{req_data[7:0]}};
        legal_c = 1'b1;
      end
      SIZE_HALF: begin
        sel_c   = req_addr_lo[1] ? 4'b1100 : 4'b0011;
        wdat_c  = {2{req_data[15:0]}};
        legal_c = ~req_addr_lo[0];
      end
      SIZE_WORD: begin
        sel_c   = 4'b1111;
        legal_c = (req_addr_lo == 2'b00);
      end
      default: ;
    endcase
  end

  // Move the addressed lane(s) down to bit 0 and zero-extend.
  always_comb begin
    rsp_shift = rsp_data >> {rsp_addr_lo, 3'b000};
    rdat_c    = rsp_data;
    case (rsp_size)
      SIZE_BYTE: rdat_c = {24'h0, rsp_shift[7:0]};
      SIZE_HALF: rdat_c = {16'h0, rsp_shift[15:0]};
      default:   rdat_c = rsp_data;
    endcase
  end

endmodule

// File: rtl/ext_tran_master.sv
// Single-outstanding Wishbone classic master driven by host register fields,
// with sticky ready/error status and a bus timeout.
module ext_tran_master
  import ext_tran_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] ext_tran_addr_i,
  input  logic [DATA_W-1:0] ext_tran_data_i,
  input  logic [1:0]        ext_tran_size_i,
  input  logic              ext_tran_write_i,
  input  logic              ext_tran_start_i,
  input  logic              ext_tran_clear_i,
  output logic [DATA_W-1:0] ext_tran_data_o,
  output logic              ext_tran_ready_o,
  output logic              ext_tran_error_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic [SEL_W-1:0]  wb_sel_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

  state_e            state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  size_e             size_q,    size_d;
  logic              cyc_q,     cyc_d;
  logic              we_q,      we_d;
  logic [ADDR_W-1:0] adr_q,     adr_d;
  logic [SEL_W-1:0]  sel_q,     sel_d;
  logic [DATA_W-1:0] wdat_q,    wdat_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic              ready_q,   ready_d;
  logic              error_q,   error_d;

  logic [SEL_W-1:0]  sel_c;
  logic [DATA_W-1:0] wdat_c;
  logic [DATA_W-1:0] rdat_c;
  logic              legal_c;
  logic              timeout_c;

  ext_tran_lanes u_lanes (
    .req_addr_lo (ext_tran_addr_i[1:0]),
    .req_size    (size_e'(ext_tran_size_i)),
    .req_data    (ext_tran_data_i),
    .rsp_addr_lo (addr_lo_q),
    .rsp_size    (size_q),
    .rsp_data    (wb_dat_i),
    .sel_c       (sel_c),
    .wdat_c      (wdat_c),
    .rdat_c      (rdat_c),
    .legal_c     (legal_c)
  );

  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_lo_d = addr_lo_q;
    size_d    = size_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    sel_d     = sel_q;
    wdat_d    = wdat_q;
    rdata_d   = rdata_q;
    ready_d   = ready_q;
    error_d   = error_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (ext_tran_start_i) begin
          addr_lo_d = ext_tran_addr_i[1:0];
          size_d    = size_e'(ext_tran_size_i);
          ready_d   = 1'b0;
          error_d   = 1'b0;
          if (legal_c) begin
            state_d = ST_BUS;
            cnt_d   = '0;
            cyc_d   = 1'b1;
            we_d    = ext_tran_write_i;
            adr_d   = {ext_tran_addr_i[ADDR_W-1:2], 2'b00};
            sel_d   = sel_c;
            wdat_d  = wdat_c;
          end else begin
            state_d = ST_DONE;
            ready_d = 1'b1;
            error_d = 1'b1;
          end
        end else if (ext_tran_clear_i) begin
          state_d = ST_IDLE;
          ready_d = 1'b0;
          error_d = 1'b0;
        end
      end
      ST_BUS: begin
        // Error and timeout take priority over a coincident ack.
        if (wb_err_i || timeout_c) begin
          state_d = ST_DONE;
          cyc_d   = 1'b0;
          ready_d = 1'b1;
          error_d = 1'b1;
          if (!we_q) rdata_d = '0;
        end else if (wb_ack_i) begin
          state_d = ST_DONE;
          cyc_d   = 1'b0;
          ready_d = 1'b1;
          if (!we_q) rdata_d = rdat_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_lo_q <= '0;
      size_q    <= SIZE_BYTE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      sel_q     <= '0;
      wdat_q    <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_lo_q <= addr_lo_d;
      size_q    <= size_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      sel_q     <= sel_d;
      wdat_q    <= wdat_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
    end
  end

  assign wb_cyc_o         = cyc_q;
  assign wb_stb_o         = cyc_q;
  assign wb_we_o          = we_q;
  assign wb_adr_o         = adr_q;
  assign wb_sel_o         = sel_q;
  assign wb_dat_o         = wdat_q;
  assign ext_tran_data_o  = rdata_q;
  assign ext_tran_ready_o = ready_q;
  assign ext_tran_error_o = error_q;

endmodule

// File: tb/tb_ext_tran_master.sv
// Directed bench for ext_tran_master with a small latency-programmable slave.
module tb_ext_tran_master;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic [31:0] ext_tran_addr_i = '0;
  logic [31:0] ext_tran_data_i = '0;
  logic [1:0]  ext_tran_size_i = '0;
  logic        ext_tran_write_i = 1'b0;
  logic        ext_tran_start_i = 1'b0;
  logic        ext_tran_clear_i = 1'b0;
  logic [31:0] ext_tran_data_o;
  logic        ext_tran_ready_o;
  logic        ext_tran_error_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // slave modes: 0 ack, 1 err, 2 silent, 3 ack+err together
  int          slv_mode  = 0;
  int          slv_lat   = 1;
  logic [31:0] slv_rdata = '0;
  int          bus_cnt   = 0;

  ext_tran_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .ext_tran_addr_i  (ext_tran_addr_i),
    .ext_tran_data_i  (ext_tran_data_i),
    .ext_tran_size_i  (ext_tran_size_i),
    .ext_tran_write_i (ext_tran_write_i),
    .ext_tran_start_i (ext_tran_start_i),
    .ext_tran_clear_i (ext_tran_clear_i),
    .ext_tran_data_o  (ext_tran_data_o),
    .ext_tran_ready_o (ext_tran_ready_o),
    .ext_tran_error_o (ext_tran_error_o),
    .wb_cyc_o         (wb_cyc_o),
    .wb_stb_o         (wb_stb_o),
    .wb_we_o          (wb_we_o),
    .wb_adr_o         (wb_adr_o),
    .wb_dat_o         (wb_dat_o),
    .wb_sel_o         (wb_sel_o),
    .wb_dat_i         (wb_dat_i),
    .wb_ack_i         (wb_ack_i),
    .wb_err_i         (wb_err_i)
  );

  always #5 clk_i = ~clk_i;

  always begin
    @(posedge clk_i);
    #2;
    if (wb_cyc_o && wb_stb_o) begin
      bus_cnt++;
      wb_ack_i = (slv_mode == 0 || slv_mode == 3) && (bus_cnt == slv_lat);
      wb_err_i = (slv_mode == 1 || slv_mode == 3) && (bus_cnt == slv_lat);
      wb_dat_i = wb_ack_i ? slv_rdata : 32'h0;
    end else begin
      bus_cnt  = 0;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = 32'h0;
    end
  end

  task automatic do_start(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size, input logic wr);
    ext_tran_addr_i  = addr;
    ext_tran_data_i  = data;
    ext_tran_size_i  = size;
    ext_tran_write_i = wr;
    ext_tran_start_i = 1'b1;
    @(posedge clk_i); #1;
    ext_tran_start_i = 1'b0;
  endtask

  task automatic run_to_done(output int cyc_n, output bit hung);
    cyc_n = 0;
    hung  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (ext_tran_ready_o) begin
        hung = 1'b0;
        break;
      end
      if (wb_cyc_o) cyc_n++;
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({ext_tran_data_o, ext_tran_ready_o, ext_tran_error_o, wb_cyc_o, wb_stb_o, wb_we_o} !== 38'h0) begin
      n_fail++; $display("FAIL reset_status: got data=%h rdy=%b err=%b cyc=%b stb=%b we=%b, want all 0",
                         ext_tran_data_o, ext_tran_ready_o, ext_tran_error_o, wb_cyc_o, wb_stb_o, wb_we_o);
    end
    n_checks++;
    if ({wb_adr_o, wb_dat_o, wb_sel_o} !== 68'h0) begin
      n_fail++; $display("FAIL reset_bus: got adr=%h dat=%h sel=%b, want 0", wb_adr_o, wb_dat_o, wb_sel_o);
    end
  endtask

  task automatic test_word_read();
    int n; bit hung;
    slv_mode = 0; slv_lat = 3; slv_rdata = 32'hCAFEBABE;
    do_start(32'h100, 32'h0, 2'b10, 1'b0);
    n_checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o} !== {3'b110, 4'b1111, 32'h100}) begin
      n_fail++; $display("FAIL word_rd_bus: got cyc=%b stb=%b we=%b sel=%b adr=%h, want 1 1 0 1111 00000100",
                         wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o);
    end
    run_to_done(n, hung);
    n_checks++;
    if (hung || n != 3) begin
      n_fail++; $display("FAIL word_rd_cycles: got %0d cyc cycles hung=%b, want 3", n, hung);
    end
    n_checks++;
    if ({ext_tran_data_o, ext_tran_ready_o, ext_tran_error_o, wb_cyc_o} !== {32'hCAFEBABE, 3'b100}) begin
      n_fail++; $display("FAIL word_rd_result: got data=%h rdy=%b err=%b cyc=%b, want cafebabe 1 0 0",
                         ext_tran_data_o, ext_tran_ready_o, ext_tran_error_o, wb_cyc_o);
    end
  endtask

  task automatic test_lanes();
    int n; bit hung;
    slv_mode = 0; slv_lat = 1;
    do_start(32'h203, 32'hFFFFFFA5, 2'b00, 1'b1);
    n_checks++;
    if ({wb_cyc_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o} !== {2'b11, 4'b1000, 32'h200, 32'hA5A5A5A5}) begin
      n_fail++; $display("FAIL byte_wr_bus: got cyc=%b we=%b sel=%b adr=%h dat=%h, want 1 1 1000 00000200 a5a5a5a5",
                         wb_cyc_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o);
    end
    run_to_done(n, hung);
    n_checks++;
    if (hung || n != 1 || ext_tran_data_o !== 32'hCAFEBABE || ext_tran_error_o !== 1'b0) begin
      n_fail++; $display("FAIL byte_wr_done: got n=%0d hung=%b data=%h err=%b, want 1 0 cafebabe 0",
                         n, hung, ext_tran_data_o, ext_tran_error_o);
    end
    slv_rdata = 32'h12345678;
    do_start(32'h202, 32'h0, 2'b01, 1'b0);
    n_checks++;
    if ({wb_we_o, wb_sel_o} !== 5'b0_1100 || ext_tran_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL half_rd_bus: got we=%b sel=%b rdy=%b, want 0 1100 0", wb_we_o, wb_sel_o, ext_tran_ready_o);
    end
    run_to_done(n, hung);
    n_checks++;
    if (hung || ext_tran_data_o !== 32'h00001234) begin
      n_fail++; $display("FAIL half_rd_data: got %h hung=%b, want 00001234", ext_tran_data_o, hung);
    end
    do_start(32'h201, 32'h0, 2'b00, 1'b0);
    n_checks++;
    if (wb_sel_o !== 4'b0010) begin
      n_fail++; $display("FAIL byte_rd_sel: got %b, want 0010", wb_sel_o);
    end
    run_to_done(n, hung);
    n_checks++;
    if (hung || ext_tran_data_o !== 32'h00000056) begin
      n_fail++; $display("FAIL byte_rd_data: got %h hung=%b, want 00000056", ext_tran_data_o, hung);
    end
  endtask

  task automatic test_illegal();
    do_start(32'h201, 32'h0, 2'b01, 1'b0);
    n_checks++;
    if ({wb_cyc_o, ext_tran_ready_o, ext_tran_error_o} !== 3'b011 || ext_tran_data_o !== 32'h56) begin
      n_fail++; $display("FAIL illegal_half: got cyc=%b rdy=%b err=%b data=%h, want 0 1 1 00000056",
                         wb_cyc_o, ext_tran_ready_o, ext_tran_error_o, ext_tran_data_o);
    end
    do_start(32'h100, 32'h0, 2'b11, 1'b0);
    n_checks++;
    if ({wb_cyc_o, ext_tran_ready_o, ext_tran_error_o} !== 3'b011) begin
      n_fail++; $display("FAIL illegal_rsvd: got cyc=%b rdy=%b err=%b, want 0 1 1", wb_cyc_o, ext_tran_ready_o, ext_tran_error_o);
    end
    do_start(32'h102, 32'h0, 2'b10, 1'b1);
    n_checks++;
    if ({wb_cyc_o, ext_tran_ready_o, ext_tran_error_o} !== 3'b011) begin
      n_fail++; $display("FAIL illegal_word: got cyc=%b rdy=%b err=%b, want 0 1 1", wb_cyc_o, ext_tran_ready_o, ext_tran_error_o);
    end
    ext_tran_clear_i = 1'b1;
    @(posedge clk_i); #1;
    ext_tran_clear_i = 1'b0;
    n_checks++;
    if ({ext_tran_ready_o, ext_tran_error_o} !== 2'b00) begin
      n_fail++; $display("FAIL clear_done: got rdy=%b err=%b, want 0 0", ext_tran_ready_o, ext_tran_error_o);
    end
  endtask

  task automatic test_timeout();
    int n; bit hung;
    slv_mode = 2;
    do_start(32'h300, 32'h0, 2'b10, 1'b0);
    run_to_done(n, hung);
    n_checks++;
    if (hung || n != 16) begin
      n_fail++; $display("FAIL timeout_cycles: got %0d hung=%b, want 16", n, hung);
    end
    n_checks++;
    if ({ext_tran_data_o, ext_tran_ready_o, ext_tran_error_o, wb_cyc_o} !== {32'h0, 3'b110}) begin
      n_fail++; $display("FAIL timeout_result: got data=%h rdy=%b err=%b cyc=%b, want 0 1 1 0",
                         ext_tran_data_o, ext_tran_ready_o, ext_tran_error_o, wb_cyc_o);
    end
  endtask

  task automatic test_err();
    int n; bit hung;
    slv_mode = 0; slv_lat = 1; slv_rdata = 32'h11223344;
    do_start(32'h100, 32'h0, 2'b10, 1'b0);
    run_to_done(n, hung);
    n_checks++;
    if (hung || ext_tran_data_o !== 32'h11223344 || ext_tran_error_o !== 1'b0) begin
      n_fail++; $display("FAIL pre_err_read: got data=%h err=%b hung=%b, want 11223344 0", ext_tran_data_o, ext_tran_error_o, hung);
    end
    slv_mode = 1; slv_lat = 2;
    do_start(32'h104, 32'h0, 2'b10, 1'b0);
    run_to_done(n, hung);
    n_checks++;
    if (hung || n != 2 || {ext_tran_data_o, ext_tran_ready_o, ext_tran_error_o} !== {32'h0, 2'b11}) begin
      n_fail++; $display("FAIL err_resp: got n=%0d data=%h rdy=%b err=%b, want 2 0 1 1",
                         n, ext_tran_data_o, ext_tran_ready_o, ext_tran_error_o);
    end
    slv_mode = 0; slv_lat = 1; slv_rdata = 32'h55667788;
    do_start(32'h108, 32'h0, 2'b10, 1'b0);
    run_to_done(n, hung);
    slv_mode = 3; slv_lat = 1; slv_rdata = 32'h99999999;
    do_start(32'h10C, 32'h0, 2'b10, 1'b0);
    run_to_done(n, hung);
    n_checks++;
    if (hung || {ext_tran_data_o, ext_tran_ready_o, ext_tran_error_o} !== {32'h0, 2'b11}) begin
      n_fail++; $display("FAIL ack_err_same: got data=%h rdy=%b err=%b, want 0 1 1",
                         ext_tran_data_o, ext_tran_ready_o, ext_tran_error_o);
    end
  endtask

  task automatic test_back_to_back();
    int n; bit hung;
    slv_mode = 0; slv_lat = 5; slv_rdata = 32'h0BADF00D;
    do_start(32'h100, 32'h0, 2'b10, 1'b0);
    do_start(32'h400, 32'hFFFFFFFF, 2'b10, 1'b1);
    ext_tran_write_i = 1'b0;
    n_checks++;
    if ({wb_cyc_o, wb_we_o, wb_adr_o} !== {2'b10, 32'h100}) begin
      n_fail++; $display("FAIL start_in_bus: got cyc=%b we=%b adr=%h, want 1 0 00000100", wb_cyc_o, wb_we_o, wb_adr_o);
    end
    ext_tran_clear_i = 1'b1;
    @(posedge clk_i); #1;
    ext_tran_clear_i = 1'b0;
    n_checks++;
    if ({wb_cyc_o, ext_tran_ready_o} !== 2'b10) begin
      n_fail++; $display("FAIL clear_in_bus: got cyc=%b rdy=%b, want 1 0", wb_cyc_o, ext_tran_ready_o);
    end
    run_to_done(n, hung);
    n_checks++;
    if (hung || n != 3 || ext_tran_data_o !== 32'h0BADF00D || ext_tran_error_o !== 1'b0) begin
      n_fail++; $display("FAIL bus_complete: got n=%0d hung=%b data=%h err=%b, want 3 0 0badf00d 0",
                         n, hung, ext_tran_data_o, ext_tran_error_o);
    end
    slv_lat = 1; slv_rdata = 32'h600DCAFE;
    ext_tran_clear_i = 1'b1;
    do_start(32'h104, 32'h0, 2'b10, 1'b0);
    ext_tran_clear_i = 1'b0;
    n_checks++;
    if ({ext_tran_ready_o, wb_cyc_o, wb_adr_o} !== {2'b01, 32'h104}) begin
      n_fail++; $display("FAIL start_clear_done: got rdy=%b cyc=%b adr=%h, want 0 1 00000104",
                         ext_tran_ready_o, wb_cyc_o, wb_adr_o);
    end
    run_to_done(n, hung);
    n_checks++;
    if (hung || ext_tran_data_o !== 32'h600DCAFE) begin
      n_fail++; $display("FAIL start_clear_data: got %h hung=%b, want 600dcafe", ext_tran_data_o, hung);
    end
  endtask

  task automatic test_reset_mid_bus();
    int n; bit hung;
    slv_mode = 2;
    do_start(32'h500, 32'h0, 2'b10, 1'b0);
    @(posedge clk_i); #1;
    #3 reset_i = 1'b0;
    #1;
    n_checks++;
    if ({wb_cyc_o, wb_stb_o, ext_tran_ready_o} !== 3'b000 || ext_tran_data_o !== 32'h0) begin
      n_fail++; $display("FAIL async_reset: got cyc=%b stb=%b rdy=%b data=%h, want 0 0 0 0",
                         wb_cyc_o, wb_stb_o, ext_tran_ready_o, ext_tran_data_o);
    end
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    n_checks++;
    if (wb_cyc_o !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got cyc=%b, want 0", wb_cyc_o);
    end
    slv_mode = 0; slv_lat = 2; slv_rdata = 32'hDEADBEEF;
    do_start(32'h600, 32'h0, 2'b10, 1'b0);
    run_to_done(n, hung);
    n_checks++;
    if (hung || n != 2 || {ext_tran_data_o, ext_tran_ready_o, ext_tran_error_o} !== {32'hDEADBEEF, 2'b10}) begin
      n_fail++; $display("FAIL post_reset_read: got n=%0d data=%h rdy=%b err=%b, want 2 deadbeef 1 0",
                         n, ext_tran_data_o, ext_tran_ready_o, ext_tran_error_o);
    end
  endtask

  initial begin
    #12;
    test_reset();
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    test_word_read();
    test_lanes();
    test_illegal();
    test_timeout();
    test_err();
    test_back_to_back();
    test_reset_mid_bus();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ext_tran_master.md
# ext_tran_master

Wishbone master that executes single host-initiated memory transactions inside `soc`, directly downstream of the FPGA host register file. It consumes the `ext_tran_*` request fields (address, data, size, write, start, clear) and issues one aligned Wishbone classic cycle with byte-lane steering. It returns read data and a sticky ready/error status that the host polls through the control register.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: cycles in BUS without `wb_ack_i`/`wb_err_i` before the transaction is aborted; minimum 2.

Ports:
- `clk_i`  in  1  system clock
- `reset_i`  in  1  asynchronous, active-low reset
- `ext_tran_addr_i`  in  32  byte address
- `ext_tran_data_i`  in  32  write data, right-justified
- `ext_tran_size_i`  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved
- `ext_tran_write_i`  in  1  1 = write, 0 = read; sampled with start
- `ext_tran_start_i`  in  1  one-cycle start pulse
- `ext_tran_clear_i`  in  1  clears ready/error
- `ext_tran_data_o`  out  32  read data, right-justified, zero-extended
- `ext_tran_ready_o`  out  1  sticky transaction-complete flag
- `ext_tran_error_o`  out  1  sticky error flag; valid when ready = 1
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1  Wishbone cycle, strobe and write enable
- `wb_adr_o`  out  32  word address: {addr[31:2], 2'b00}
- `wb_dat_o`  out  32  lane-replicated write data
- `wb_sel_o`  out  4  byte selects
- `wb_dat_i`  in  32  read data
- `wb_ack_i`, `wb_err_i`  in  1  slave terminate

## Operation
- States: IDLE, BUS, DONE.
- **IDLE/DONE + start:**
  - Latch addr, size, write and data.
  - Clear ready and error.
  - Aligned, legal request → BUS.
  - Illegal request → DONE with error = 1 and no bus cycle. Illegal means size 11, half with addr[0] = 1, or word with addr[1:0] ≠ 0.
- **BUS:**
  - cyc = stb = 1; we, adr, sel and dat held stable.
  - ack → DONE, ready = 1. A read captures the extracted data.
  - err → DONE, ready = 1, error = 1. Read data_o = 0.
  - Timeout counter reaches TIMEOUT_CYCLES → same as err.
  - ack and err in the same cycle: err wins.
- **DONE:** ready held. clear → IDLE with ready = error = 0.
- **Lane steering (little-endian):**
  - byte: sel = 1 << addr[1:0]; dat_o = {4{data[7:0]}}.
  - half: sel = addr[1] ? 1100 : 0011; dat_o = {2{data[15:0]}}.
  - word: sel = 1111.
  - Reads return the selected lane(s) shifted to bit 0, zero-extended.
- Writes leave `ext_tran_data_o` unchanged.
- start in BUS is ignored. clear in BUS is ignored; it does not abort.
- start and clear in the same cycle in IDLE/DONE: start wins.

## Timing
- Reset: all outputs 0 (including `ext_tran_data_o`), state IDLE, counter 0. The reset edge drops cyc/stb immediately (asynchronous), including mid-cycle.
- All outputs are registered.
- Handshake sequence:
  - start sampled at edge N.
  - cyc/stb high from N+1.
  - ack sampled at edge M.
  - cyc/stb low and ready/data valid after edge M.
- Minimum latency is 2 edges (start → ready) when ack returns in the first BUS cycle.
- Illegal request: ready/error high 1 edge after start.
- The timeout counter increments each BUS cycle and resets on entering BUS.
- Timeout at TIMEOUT_CYCLES edges after BUS entry → cyc low on that edge.
- One transaction outstanding at most. No pipelined Wishbone (stall not used).

## Structure
- Package `ext_tran_pkg` holds:
  - size encodings SIZE_BYTE/HALF/WORD/RSVD;
  - state enum IDLE/BUS/DONE;
  - the width of the timeout counter, $clog2(TIMEOUT_CYCLES+1).
- Sub-module `ext_tran_lanes`: combinational sel generation, write replication, read extraction and alignment check. The FSM, capture registers and timeout live in the top.

## Test plan
- Word read at 0x100, slave acks after 3 cycles with 0xCAFEBABE → sel 1111, `ext_tran_data_o` = 0xCAFEBABE, ready = 1, error = 0, cyc high for exactly 3 cycles.
- Byte write 0xA5 at 0x203 → sel 1000, `wb_dat_o` = 0xA5A5A5A5, we = 1; then a half read at 0x202 with `wb_dat_i` = 0x12345678 → data_o = 0x00001234.
- Half at 0x201 and size 11 → no cyc asserted, ready = error = 1 one edge after start.
- Slave never responds, TIMEOUT_CYCLES = 16 → cyc drops after 16 cycles, error = 1, data_o = 0.
- Second start during BUS → ignored. clear during BUS → ignored. start + clear in DONE → new transaction starts and ready drops.
- `reset_i` low mid-BUS → cyc/stb/ready immediately 0. After release, a fresh word read completes normally.
